// File: rtl/instruction_fetcher_if.sv
// instruction_fetcher_if: fetch handshake to the memory controller and issue port to the decoder
interface instruction_fetcher_if;
  logic        rdy_in;
  logic        roll_back;
  logic [31:0] roll_back_pc;
  logic        fetch_start;
  logic [31:0] pc;
  logic        finish_fetch;
  logic [31:0] instruction_in;
  logic        issue_ready;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc_out;
  logic [31:0] inst_pred_pc_out;
  logic        iq_full;
  modport master (
    input  rdy_in, roll_back, roll_back_pc, finish_fetch, instruction_in, issue_ready,
    output fetch_start, pc, inst_valid, inst_out, inst_pc_out, inst_pred_pc_out, iq_full
  );
  modport slave (
    output rdy_in, roll_back, roll_back_pc, finish_fetch, instruction_in, issue_ready,
    input  fetch_start, pc, inst_valid, inst_out, inst_pc_out, inst_pred_pc_out, iq_full
  );
endinterface

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: PC owner, single-outstanding fetch requester and circular instruction queue
module instruction_fetcher #(
  parameter int          IQ_DEPTH  = 16,
  parameter int          IQ_ADDR_W = 4,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic                  clk_in,
  input logic                  rst_in,
  instruction_fetcher_if.master bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;
  localparam logic [IQ_ADDR_W:0] L_DEPTH = (IQ_ADDR_W+1)'(IQ_DEPTH);
  state_t               r_state, w_next_state;
  logic [IQ_ADDR_W-1:0] r_head, r_tail;
  logic [IQ_ADDR_W:0]   r_count;
  logic [31:0]          r_pc, w_next_pc, w_jal_imm;
  logic [95:0]          r_iq [IQ_DEPTH];
  logic                 w_push, w_pop;

  // Static next-PC prediction (JAL taken, else PC+4) and queue push/pop decode
  always_comb begin
    w_jal_imm = {{11{bus.instruction_in[31]}}, bus.instruction_in[31], bus.instruction_in[19:12],
                 bus.instruction_in[20], bus.instruction_in[30:21], 1'b0};
    w_next_pc = r_pc + ((bus.instruction_in[6:0] == 7'b1101111) ? w_jal_imm : 32'd4);
    w_push    = (r_state == S_WAIT) && bus.finish_fetch;
    w_pop     = (r_count != '0) && bus.issue_ready;
  end

  // Request whenever the queue has room, hold until completion, abort on redirect
  always_comb begin
    w_next_state = bus.roll_back ? S_IDLE :
                   (r_state == S_IDLE) ? ((r_count < L_DEPTH) ? S_WAIT : S_IDLE) :
                   (bus.finish_fetch ? S_IDLE : S_WAIT);
  end

  // Fetch state register; a low rdy_in freezes it
  always_ff @(posedge clk_in) begin
    if (rst_in)
      r_state <= S_IDLE;
    else if (bus.rdy_in)
      r_state <= w_next_state;
  end

  // PC, queue pointers and storage; redirect flushes and overrides any push/pop
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_pc    <= RESET_PC;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int i = 0; i < IQ_DEPTH; i++)
        r_iq[i] <= '0;
    end else if (bus.rdy_in) begin
      if (bus.roll_back) begin
        r_pc    <= bus.roll_back_pc;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_iq[r_tail] <= {bus.instruction_in, r_pc, w_next_pc};
          r_tail       <= r_tail + IQ_ADDR_W'(1);
          r_pc         <= w_next_pc;
        end
        if (w_pop)
          r_head <= r_head + IQ_ADDR_W'(1);
        r_count <= r_count + (IQ_ADDR_W+1)'(w_push) - (IQ_ADDR_W+1)'(w_pop);
      end
    end
  end

  assign bus.fetch_start = (r_state == S_WAIT);
  assign bus.pc          = r_pc;
  assign bus.inst_valid  = (r_count != '0);
  assign bus.iq_full     = (r_count == L_DEPTH);
  assign {bus.inst_out, bus.inst_pc_out, bus.inst_pred_pc_out} = r_iq[r_head];
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: randomized controller/consumer stimulus against a queue-based reference model
module tb_instruction_fetcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  instruction_fetcher_if bus();
  instruction_fetcher #(.IQ_DEPTH(16), .IQ_ADDR_W(4), .RESET_PC(32'h0)) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {logic [31:0] ins; logic [31:0] pc; logic [31:0] pred;} ent_t;
  ent_t        q[$];
  logic [31:0] m_pc;
  bit          m_fs;
  int          n_chk = 0, n_fail = 0;
  bit          busy, rand_ins, rb_on_fin, pop_on_fin, rb_seen;
  int          cnt, lat;

  function automatic logic [31:0] pred(input logic [31:0] p, input logic [31:0] i);
    logic signed [20:0] o21;
    logic signed [31:0] off;
    o21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    off = o21;
    return (i[6:0] == 7'h6F) ? p + off : p + 32'd4;
  endfunction

  function automatic logic [31:0] imem(input logic [31:0] p);
    logic [31:0] w;
    if (!rand_ins) return (p == 32'h10) ? 32'h1000006F : 32'h00000013;
    w = $urandom;
    case ($urandom % 4)
      0: w[6:0] = 7'h6F;
      1: w = 32'h00000013;
      default: if (w[6:0] == 7'h6F) w[6:0] = 7'h33;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("fetch_start", 32'(bus.fetch_start), 32'(m_fs));
    chk("pc", bus.pc, m_pc);
    chk("inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
    chk("iq_full", 32'(bus.iq_full), 32'(q.size() == 16));
    if (q.size() != 0) begin
      chk("inst_out", bus.inst_out, q[0].ins);
      chk("inst_pc_out", bus.inst_pc_out, q[0].pc);
      chk("inst_pred_pc_out", bus.inst_pred_pc_out, q[0].pred);
    end
  endtask

  task automatic step(input bit rdy, input bit ir, input bit rb, input logic [31:0] rbpc);
    bit fin, p_rb, p_ir, push, pop, nfs;
    logic [31:0] np;
    check_model();
    fin = 1'b0;
    if (rdy) begin
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          fin  = 1'b1;
          busy = 1'b0;
        end
      end else if (bus.fetch_start) begin
        busy = 1'b1;
        cnt  = lat;
      end
    end
    p_rb = rdy && (rb || (rb_on_fin && fin));
    if (rb_on_fin && fin) rb_seen = 1'b1;
    p_ir = pop_on_fin ? fin : ir;
    if (p_rb) busy = 1'b0;
    bus.rdy_in         = rdy;
    bus.issue_ready    = p_ir;
    bus.roll_back      = p_rb;
    bus.roll_back_pc   = p_rb ? rbpc : $urandom;
    bus.finish_fetch   = fin;
    bus.instruction_in = fin ? imem(bus.pc) : $urandom;
    if (rdy) begin
      if (p_rb) begin
        q.delete();
        m_pc = rbpc;
        m_fs = 1'b0;
      end else begin
        push = m_fs && fin;
        pop  = (q.size() != 0) && p_ir;
        nfs  = m_fs ? !fin : (q.size() < 16);
        np   = pred(m_pc, bus.instruction_in);
        if (pop) void'(q.pop_front());
        if (push) begin
          q.push_back('{bus.instruction_in, m_pc, np});
          m_pc = np;
        end
        m_fs = nfs;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bus.rdy_in = 1'b1; bus.roll_back = 1'b0; bus.roll_back_pc = '0;
    bus.finish_fetch = 1'b0; bus.instruction_in = '0; bus.issue_ready = 1'b0;
    busy = 0; rand_ins = 0; rb_on_fin = 0; pop_on_fin = 0; rb_seen = 0; lat = 5; cnt = 0;
    chk("model_jal_pos", pred(32'h10, 32'h1000006F), 32'h110);
    chk("model_jal_neg", pred(32'h0, 32'hFFDFF06F), 32'hFFFFFFFC);
    chk("model_pc4_wrap", pred(32'hFFFFFFFC, 32'h13), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    q.delete(); m_pc = 32'h0; m_fs = 1'b0;
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_fetch_start", 32'(bus.fetch_start), 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_iq_full", 32'(bus.iq_full), 32'h0);
    chk("rst_inst_out", bus.inst_out, 32'h0);
    chk("rst_inst_pc_out", bus.inst_pc_out, 32'h0);
    chk("rst_inst_pred_pc_out", bus.inst_pred_pc_out, 32'h0);

    // nop stream with latency 5, JAL at 0x10
    for (int i = 0; i < 100 && q.size() < 1; i++) step(1, 0, 0, 0);
    chk("first_valid", 32'(bus.inst_valid), 32'h1);
    chk("first_inst", bus.inst_out, 32'h13);
    chk("first_pc", bus.inst_pc_out, 32'h0);
    chk("first_pred", bus.inst_pred_pc_out, 32'h4);
    for (int i = 0; i < 200 && q.size() < 5; i++) step(1, 0, 0, 0);
    chk("jal_next_pc", bus.pc, 32'h110);
    chk("jal_entry_pred", (q.size() == 5) ? q[4].pred : 32'hX, 32'h110);

    // fill to 16 and stall
    lat = 1;
    for (int i = 0; i < 300 && q.size() < 16; i++) step(1, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0);
    chk("full_iq_full", 32'(bus.iq_full), 32'h1);
    chk("full_no_fetch", 32'(bus.fetch_start), 32'h0);
    step(1, 1, 0, 0);
    chk("pop_not_full", 32'(bus.iq_full), 32'h0);
    chk("pop_fetch_lag", 32'(bus.fetch_start), 32'h0);
    step(1, 0, 0, 0);
    chk("pop_fetch_issue", 32'(bus.fetch_start), 32'h1);

    // roll_back coincident with finish_fetch
    lat = 3; rb_on_fin = 1; rb_seen = 0;
    for (int i = 0; i < 50 && !rb_seen; i++) step(1, 0, 0, 32'h200);
    chk("rb_seen", 32'(rb_seen), 32'h1);
    rb_on_fin = 0;
    chk("rb_flush_valid", 32'(bus.inst_valid), 32'h0);
    chk("rb_fetch_low", 32'(bus.fetch_start), 32'h0);
    step(1, 0, 0, 0);
    chk("rb_refetch", 32'(bus.fetch_start), 32'h1);
    chk("rb_refetch_pc", bus.pc, 32'h200);

    // freeze mid-WAIT
    lat = 6;
    repeat (2) step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    chk("frz_fetch", 32'(bus.fetch_start), 32'h1);
    chk("frz_pc", bus.pc, 32'h200);
    chk("frz_valid", 32'(bus.inst_valid), 32'h0);
    for (int i = 0; i < 50 && m_pc == 32'h200; i++) step(1, 1, 0, 0);
    chk("frz_resume_pc", bus.pc, 32'h204);

    // push+pop at count 1 across pointer wrap
    lat = 2; rand_ins = 1;
    for (int i = 0; i < 50 && q.size() < 1; i++) step(1, 0, 0, 0);
    pop_on_fin = 1;
    for (int i = 0; i < 200; i++) begin
      step(1, 0, 0, 0);
      if (i % 20 == 19) chk("pp_valid", 32'(bus.inst_valid), 32'h1);
    end
    pop_on_fin = 0;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      bit ir;
      lat = $urandom_range(1, 6);
      ir  = ((i / 150) % 3 == 0) ? ($urandom % 8 == 0) : ($urandom % 3 != 0);
      step($urandom % 10 != 0, ir, $urandom % 40 == 0, $urandom & 32'hFFFFFFFC);
    end
    check_model();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
